// File: rtl/comm_ctrl_pkg.sv
// Shared types and response codes for the remote command scheduler.
package comm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    DONE
  } sched_state_t;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'h5A;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr_i, wrapping; purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/remote_cmd_sched.sv
// Arbitrates NREQ requesters onto one UART command link with NACK/timeout resends.
// Requesters hold req until their done pulse; one idle cycle separates transactions.
module remote_cmd_sched
  import comm_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int RESP_TO   = 1000000,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] req_cmd,
  output logic [NREQ-1:0]    done,
  output logic [7:0]         resp_data,
  output logic               resp_err,
  output logic               busy,
  output logic               snd_cmd,
  output logic [15:0]        cmd,
  input  logic               cmd_snt,
  input  logic               resp_rx_rdy,
  input  logic [7:0]         resp_rx_data,
  output logic               resp_clr_rx_rdy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (RESP_TO > 1) ? $clog2(RESP_TO) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_t  state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic          clr;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            can_retry;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign arb_any   = |arb_gnt;
  assign can_retry = (retry_q < RW'(MAX_RETRY));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cmd_d       = cmd_q;
    busy_d      = busy_q;
    retry_d     = retry_q;
    to_cnt_d    = to_cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    clr         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale byte in the link must be drained before any grant.
        if (resp_rx_rdy) begin
          clr = 1'b1;
        end else if (arb_any) begin
          owner_d = arb_idx;
          cmd_d   = req_cmd[{arb_idx, 4'b0000} +: 16];
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        to_cnt_d = '0;
        state_d  = WAIT_SNT;
      end
      WAIT_SNT: begin
        if (cmd_snt) begin
          to_cnt_d = '0;
          state_d  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        to_cnt_d = to_cnt_q + CW'(1);
        if (resp_rx_rdy) begin
          clr         = 1'b1;
          resp_data_d = resp_rx_data;
          if (resp_rx_data == RESP_NACK && can_retry) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            resp_err_d = 1'b0;
            state_d    = DONE;
          end
        end else if (to_cnt_q == CW'(RESP_TO - 1)) begin
          if (can_retry) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            resp_data_d = 8'h00;
            resp_err_d  = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        ptr_d   = owner_q;
        busy_d  = 1'b0;
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= IW'(NREQ - 1);
      cmd_q       <= 16'h0000;
      busy_q      <= 1'b0;
      retry_q     <= '0;
      to_cnt_q    <= '0;
      resp_data_q <= 8'h00;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cmd_q       <= cmd_d;
      busy_q      <= busy_d;
      retry_q     <= retry_d;
      to_cnt_q    <= to_cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    done = '0;
    if (state_q == DONE) done[owner_q] = 1'b1;
  end

  assign busy            = busy_q;
  assign cmd             = cmd_q;
  assign resp_data       = resp_data_q;
  assign resp_err        = resp_err_q;
  assign snd_cmd         = (state_q == SEND);
  assign resp_clr_rx_rdy = clr;

endmodule

// File: tb/tb_remote_cmd_sched.sv
// Directed bench: link model (cmd_snt 20 clk after snd_cmd, queued replies) plus linear test steps.
module tb_remote_cmd_sched;

  localparam int NREQ = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [63:0]     req_cmd;
  logic [NREQ-1:0] done;
  logic [7:0]      resp_data;
  logic            resp_err;
  logic            busy;
  logic            snd_cmd;
  logic [15:0]     cmd;
  logic            cmd_snt;
  logic            resp_rx_rdy;
  logic [7:0]      resp_rx_data;
  logic            resp_clr_rx_rdy;

  remote_cmd_sched #(.NREQ(NREQ), .RESP_TO(64), .MAX_RETRY(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_cmd         (req_cmd),
    .done            (done),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .busy            (busy),
    .snd_cmd         (snd_cmd),
    .cmd             (cmd),
    .cmd_snt         (cmd_snt),
    .resp_rx_rdy     (resp_rx_rdy),
    .resp_rx_data    (resp_rx_data),
    .resp_clr_rx_rdy (resp_clr_rx_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // link model / monitor state
  int              cyc = 0;
  int              snd_count = 0;
  int              clr_count = 0;
  int              done_count = 0;
  int              done_cyc = 0;
  int              clr_cyc = 0;
  int              stab_bad = 0;
  int              snt_at = 0;
  int              resp_at = 0;
  int              resp_delay = 3;
  bit              inflight = 0;
  bit              pend = 0;
  bit              inject = 0;
  logic [7:0]      pend_byte;
  logic [15:0]     inflight_cmd;
  logic [7:0]      last_data;
  logic            last_err;
  logic            cmd_snt_n, rdy_n;
  logic [7:0]      data_n;
  logic [7:0]      reply_q[$];
  int              snd_cyc_q[$];
  logic [15:0]     sent_q[$];
  logic [NREQ-1:0] done_q[$];
  logic [NREQ-1:0] exp_o[5];

  initial begin
    cmd_snt = 1'b0; resp_rx_rdy = 1'b0; resp_rx_data = 8'h00;
    cmd_snt_n = 1'b0; rdy_n = 1'b0; data_n = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (resp_clr_rx_rdy) begin
        clr_count++;
        clr_cyc = cyc;
        rdy_n = 1'b0;
      end
      if (done !== '0) begin
        done_count++;
        done_q.push_back(done);
        last_data = resp_data;
        last_err  = resp_err;
        done_cyc  = cyc;
      end
      if (inflight) begin
        if (cmd !== inflight_cmd) stab_bad++;
        if (cyc == snt_at) inflight = 1'b0;
        else if (cyc + 1 == snt_at) cmd_snt_n = 1'b1;
      end
      if (pend && cyc + 1 == resp_at) begin
        rdy_n = 1'b1; data_n = pend_byte; pend = 1'b0;
      end
      if (snd_cmd) begin
        snd_count++;
        snd_cyc_q.push_back(cyc);
        sent_q.push_back(cmd);
        inflight = 1'b1; inflight_cmd = cmd; snt_at = cyc + 20; cmd_snt_n = 1'b0;
        if (reply_q.size() > 0) begin
          pend = 1'b1; pend_byte = reply_q.pop_front(); resp_at = snt_at + resp_delay;
        end
      end
      if (inject) begin
        inject = 1'b0; rdy_n = 1'b1; data_n = 8'h77;
      end
      @(posedge clk);
      #1;
      cmd_snt = cmd_snt_n; resp_rx_rdy = rdy_n; resp_rx_data = data_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int base;
    int i;
    base = done_count;
    i = 0;
    while (done_count == base && i < max_cyc) begin
      tick(1);
      i++;
    end
    chk(tag, done_count != base, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, n;
    exp_o = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; req = '0; req_cmd = '0;
    tick(2);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_snd", snd_cmd, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_clr", resp_clr_rx_rdy, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_data", resp_data, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 1: single ACKed transaction
    s0 = snd_count; c0 = clr_count;
    reply_q.push_back(8'hA5); resp_delay = 3;
    req_cmd[15:0] = 16'h1234; req = 4'b0001;
    tick(1);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_snd", snd_cmd, 1);
    chk("t1_cmd", cmd, 16'h1234);
    wait_done("t1_wait", 200);
    chk("t1_done", done_q[done_q.size()-1], 4'b0001);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_err", last_err, 0);
    chk("t1_nsnd", snd_count - s0, 1);
    chk("t1_nclr", clr_count - c0, 1);
    chk("t1_sent", sent_q[sent_q.size()-1], 16'h1234);
    chk("t1_stable", stab_bad, 0);
    chk("t1_lat", done_cyc - snd_cyc_q[snd_cyc_q.size()-1], 24);
    req = '0;
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // 2: round robin from reset pointer, then wrap
    tick(1); rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    for (int k = 0; k < 8; k++) reply_q.push_back(8'hA5);
    req_cmd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    n = done_q.size();
    req = 4'b1111;
    for (int k = 0; k < 7; k++) wait_done("t2_wait", 200);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), done_q[n+k], exp_o[k]);
    chk("t2_owner2", done_q[n+6], 4'b0100);
    req = 4'b0101;
    wait_done("t2_wait_wrap", 200);
    chk("t2_wrap", done_q[n+7], 4'b0001);
    chk("t2_wrap_cmd", sent_q[sent_q.size()-1], 16'h1111);
    req = '0;
    tick(1);

    // 3: NACK resends
    req_cmd[31:16] = 16'hBEEF;
    reply_q.push_back(8'h5A); reply_q.push_back(8'h5A); reply_q.push_back(8'hA5);
    s0 = snd_count; c0 = clr_count;
    req = 4'b0010;
    wait_done("t3_wait", 500);
    chk("t3_nsnd", snd_count - s0, 3);
    for (int k = 1; k <= 3; k++) chk($sformatf("t3_cmd%0d", k), sent_q[sent_q.size()-k], 16'hBEEF);
    chk("t3_done", done_q[done_q.size()-1], 4'b0010);
    chk("t3_data", last_data, 8'hA5);
    chk("t3_err", last_err, 0);
    chk("t3_nclr", clr_count - c0, 3);
    req = '0;
    tick(1);
    reply_q.push_back(8'h5A); reply_q.push_back(8'h5A); reply_q.push_back(8'h5A);
    s0 = snd_count;
    req = 4'b0010;
    wait_done("t3b_wait", 500);
    chk("t3b_nsnd", snd_count - s0, 3);
    chk("t3b_data", last_data, 8'h5A);
    chk("t3b_err", last_err, 0);
    req = '0;
    tick(1);

    // 4: timeouts, then a byte on the final counter value
    req_cmd[47:32] = 16'h0F0F;
    s0 = snd_count;
    req = 4'b0100;
    wait_done("t4_wait", 600);
    n = snd_cyc_q.size();
    chk("t4_nsnd", snd_count - s0, 3);
    chk("t4_gap1", snd_cyc_q[n-2] - snd_cyc_q[n-3], 85);
    chk("t4_gap2", snd_cyc_q[n-1] - snd_cyc_q[n-2], 85);
    chk("t4_gap_done", done_cyc - snd_cyc_q[n-1], 85);
    chk("t4_done", done_q[done_q.size()-1], 4'b0100);
    chk("t4_data", last_data, 8'h00);
    chk("t4_err", last_err, 1);
    req = '0;
    tick(1);
    reply_q.push_back(8'h3C); resp_delay = 64;
    s0 = snd_count;
    req = 4'b0100;
    wait_done("t4b_wait", 300);
    chk("t4b_nsnd", snd_count - s0, 1);
    chk("t4b_data", last_data, 8'h3C);
    chk("t4b_err", last_err, 0);
    chk("t4b_lat", done_cyc - snd_cyc_q[snd_cyc_q.size()-1], 85);
    req = '0; resp_delay = 3;
    tick(1);

    // 5: unsolicited byte flushed before grant; owner drops req mid-send
    reply_q.push_back(8'hA5);
    inject = 1'b1;
    tick(1);
    req = 4'b0001;
    @(negedge clk);
    chk("t5_flush_clr", resp_clr_rx_rdy, 1);
    chk("t5_flush_busy", busy, 0);
    tick(1);
    @(negedge clk);
    chk("t5_gnt_clr", resp_clr_rx_rdy, 0);
    chk("t5_gnt_snd", snd_cmd, 0);
    tick(1);
    @(negedge clk);
    chk("t5_snd", snd_cmd, 1);
    chk("t5_busy", busy, 1);
    tick(5);
    req = '0;
    chk("t5_gnt_delay", snd_cyc_q[snd_cyc_q.size()-1] - clr_cyc, 2);
    wait_done("t5_wait", 200);
    chk("t5_done", done_q[done_q.size()-1], 4'b0001);
    chk("t5_data", last_data, 8'hA5);
    tick(1);

    // 6: reset mid WAIT_RESP, then normal service
    req_cmd[63:48] = 16'hCAFE;
    req = 4'b1000;
    tick(30);
    @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    chk("t6_cmd_pre", cmd, 16'hCAFE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_snd", snd_cmd, 0);
    chk("t6_done", done, 0);
    chk("t6_cmd", cmd, 16'h0000);
    tick(1);
    req = '0; rst = 1'b0;
    tick(1);
    reply_q.push_back(8'hA5);
    req = 4'b0010;
    wait_done("t6_wait", 200);
    chk("t6b_done", done_q[done_q.size()-1], 4'b0010);
    chk("t6b_data", last_data, 8'hA5);
    chk("t6b_err", last_err, 0);
    chk("t6b_cmd", sent_q[sent_q.size()-1], 16'hBEEF);
    chk("stable_all", stab_bad, 0);
    req = '0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
